// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared types and defaults for the boot-time instruction memory loader.
//   loader_state_t  : loader FSM states
//   BYTES_PER_WORD  : stream bytes per instruction word (high byte first)
//   DEF_ADDR_WIDTH  : default imem word-address width
//   DEF_DATA_WIDTH  : default instruction width
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 2;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
// Fills the instruction memory from a byte stream before the CPU runs.
// Stream format: length byte (1..WORD_COUNT), 2 bytes per word (high first),
// then an XOR checksum over every preceding byte of the load.
// The CPU is held until a load completes with a matching checksum.
//
// Ports:
//   i_clk        : clock, rising edge
//   i_reset      : asynchronous active-high reset
//   i_start      : one-cycle pulse, starts a load from IDLE/DONE/ERR
//   i_byte_valid : stream byte valid
//   i_byte_data  : stream byte
//   o_byte_ready : loader accepts a byte this cycle
//   o_mem_we     : imem write enable (one cycle per word)
//   o_mem_addr   : imem write word address
//   o_mem_wdata  : imem write data
//   o_cpu_hold   : stall the core (low only in DONE)
//   o_done       : load finished with good checksum
//   o_error      : load aborted (bad length or checksum)
//
// All outputs decode registered state only; no input reaches an output
// combinationally.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WORD_COUNT = 2 ** ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte_data,
    output logic                  o_byte_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_done,
    output logic                  o_error
);

    loader_state_t         r_state;
    loader_state_t         w_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_last;   // len-1, the final word address
    logic [7:0]            r_acc;
    logic [7:0]            r_hi;
    logic [7:0]            r_lo;

    logic w_xfer;
    logic w_len_bad;
    logic w_restart;

    assign o_byte_ready = (r_state == ST_LEN) || (r_state == ST_HI) ||
                          (r_state == ST_LO)  || (r_state == ST_CHK);
    assign w_xfer       = i_byte_valid && o_byte_ready;
    assign w_len_bad    = (i_byte_data == 8'd0) ||
                          ({24'd0, i_byte_data} > 32'(WORD_COUNT));
    assign w_restart    = i_start && ((r_state == ST_IDLE) ||
                          (r_state == ST_DONE) || (r_state == ST_ERR));

    // state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (i_start) w_next = ST_LEN;
            ST_LEN:   if (w_xfer) w_next = w_len_bad ? ST_ERR : ST_HI;
            ST_HI:    if (w_xfer) w_next = ST_LO;
            ST_LO:    if (w_xfer) w_next = ST_WRITE;
            ST_WRITE: w_next = (r_idx == r_last) ? ST_CHK : ST_HI;
            ST_CHK:   if (w_xfer) w_next = (i_byte_data == r_acc) ? ST_DONE : ST_ERR;
            default:  w_next = ST_IDLE;
        endcase
    end

    // datapath: word index, checksum accumulator, byte assembly
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx  <= '0;
            r_last <= '0;
            r_acc  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            if (w_restart) begin
                r_idx <= '0;
                r_acc <= '0;
            end
            if (w_xfer) begin
                case (r_state)
                    ST_LEN: begin
                        // only meaningful when the length is in range
                        r_last <= ADDR_WIDTH'(i_byte_data - 8'd1);
                        r_acc  <= i_byte_data;
                    end
                    ST_HI: begin
                        r_hi  <= i_byte_data;
                        r_acc <= r_acc ^ i_byte_data;
                    end
                    ST_LO: begin
                        r_lo  <= i_byte_data;
                        r_acc <= r_acc ^ i_byte_data;
                    end
                    default: ;
                endcase
            end
            // index stops at len-1 so it never wraps
            if ((r_state == ST_WRITE) && (r_idx != r_last))
                r_idx <= r_idx + ADDR_WIDTH'(1);
        end
    end

    assign o_mem_we    = (r_state == ST_WRITE);
    assign o_mem_addr  = r_idx;
    assign o_mem_wdata = DATA_WIDTH'({r_hi, r_lo});
    assign o_cpu_hold  = (r_state != ST_DONE);
    assign o_done      = (r_state == ST_DONE);
    assign o_error     = (r_state == ST_ERR);

endmodule
